// File: rtl/calc_pkg.sv
// Shared types and constants for the multi-digit calculator: FSM states,
// command encodings, status codes and display glyphs.
package calc_pkg;

  typedef enum logic [2:0] {
    ESPERA_A,
    ESPERA_B,
    CALC,
    RESULT,
    ERRO
  } estados_calc;

  localparam logic [3:0] CMD_ADD = 4'd10;
  localparam logic [3:0] CMD_SUB = 4'd11;
  localparam logic [3:0] CMD_MUL = 4'd12;
  localparam logic [3:0] CMD_DIV = 4'd13;
  localparam logic [3:0] CMD_EQ  = 4'd14;
  localparam logic [3:0] CMD_CLR = 4'd15;

  localparam logic [1:0] ST_ENTER  = 2'b00;
  localparam logic [1:0] ST_BUSY   = 2'b01;
  localparam logic [1:0] ST_RESULT = 2'b10;
  localparam logic [1:0] ST_ERROR  = 2'b11;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [3:0] ERR_GLYPH = 4'hE;

  // Largest value representable on an ndig-digit decimal display.
  function automatic longint max_value(input int ndig);
    longint v;
    v = 1;
    for (int i = 0; i < ndig; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH+1 clocks from
// start to done. The bcd output is only meaningful while done is high.
module bin2bcd_seq #(
  parameter int WIDTH = 27,
  parameter int NDIG  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [4*NDIG-1:0] work_q, work_d, adj;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // A start always wins over an in-flight conversion, so stale results never
  // reach the done/bcd outputs.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      shift_d = bin;
      work_d  = '0;
      cnt_d   = CNTW'(WIDTH);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      shift_d = shift_q << 1;
      work_d  = {adj[4*NDIG-2:0], shift_q[WIDTH-1]};
      cnt_d   = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNTW'(1)) && !start;
  assign bcd  = {adj[4*NDIG-2:0], shift_q[WIDTH-1]};

endmodule

// File: rtl/calc_multi.sv
// Multi-digit calculator: command FSM with iterative ALU, BCD snapshot of the
// current entry/result, and a time-multiplexed display scanner.
module calc_multi
  import calc_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int WIDTH    = 27,
  parameter int SCAN_DIV = 4,
  parameter int POSW     = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      cmd,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  output logic [1:0]      status,
  output logic [3:0]      data,
  output logic [POSW-1:0] pos
);

  localparam int WIDE = WIDTH + 4;
  localparam int ACCW = WIDTH + 1;
  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [WIDE-1:0] MAXVAL = WIDE'(max_value(NDIG));

  estados_calc      state_q, state_d;
  logic [WIDTH-1:0] digits_q, digits_d;
  logic [WIDTH-1:0] rega_q, rega_d, regb_q, regb_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] count_q, count_d, aux_q, aux_d, rem_q, rem_d;
  logic [3:0]       op_q, op_d;
  logic             setup_q, setup_d;
  logic [1:0]       status_q, status_d;
  logic             ready_q, ready_d;
  logic             conv_start_q, conv_start_d;

  logic             accept, is_digit, is_op, digit_ok;
  logic [WIDE-1:0]  digit_next;

  logic [4*NDIG-1:0] conv_bcd, snap_q, snap_d;
  logic              conv_done, conv_busy_unused;

  logic [DIVW-1:0]   div_q, div_d;
  logic [POSW-1:0]   pos_q, pos_d, msd;
  logic [3:0]        data_q, data_d;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    rega_d   = rega_q;
    regb_d   = regb_q;
    acc_d    = acc_q;
    count_d  = count_q;
    aux_d    = aux_q;
    rem_d    = rem_q;
    op_d     = op_q;
    setup_d  = 1'b0;

    accept     = cmd_valid && ready_q;
    is_digit   = (cmd <= 4'd9);
    is_op      = (cmd >= CMD_ADD) && (cmd <= CMD_DIV);
    digit_next = {4'b0000, digits_q} * WIDE'(10) + WIDE'(cmd);
    digit_ok   = (digit_next <= MAXVAL);

    if (accept && cmd == CMD_CLR) begin
      state_d  = ESPERA_A;
      digits_d = '0;
      rega_d   = '0;
      regb_d   = '0;
      acc_d    = '0;
      count_d  = '0;
      aux_d    = '0;
      rem_d    = '0;
      op_d     = CMD_ADD;
    end else begin
      unique case (state_q)
        ESPERA_A: begin
          if (accept && is_digit) begin
            if (digit_ok) digits_d = digit_next[WIDTH-1:0];
          end else if (accept && is_op) begin
            rega_d   = digits_q;
            op_d     = cmd;
            digits_d = '0;
            state_d  = ESPERA_B;
          end
        end
        ESPERA_B: begin
          if (accept && is_digit) begin
            if (digit_ok) digits_d = digit_next[WIDTH-1:0];
          end else if (accept && is_op) begin
            op_d = cmd;
          end else if (accept && cmd == CMD_EQ) begin
            regb_d  = digits_q;
            state_d = CALC;
            setup_d = 1'b1;
          end
        end
        // First CALC cycle loads the ALU; later cycles iterate, then retire.
        CALC: begin
          if (setup_q) begin
            if (op_q == CMD_ADD) begin
              acc_d = {1'b0, rega_q} + {1'b0, regb_q};
            end else if (op_q == CMD_SUB) begin
              if (rega_q < regb_q) state_d = ERRO;
              else acc_d = {1'b0, rega_q - regb_q};
            end else if (op_q == CMD_MUL) begin
              acc_d = '0;
              if (rega_q < regb_q) begin
                count_d = rega_q;
                aux_d   = regb_q;
              end else begin
                count_d = regb_q;
                aux_d   = rega_q;
              end
            end else begin
              if (regb_q == '0) begin
                state_d = ERRO;
              end else begin
                acc_d = '0;
                rem_d = rega_q;
              end
            end
          end else if (op_q == CMD_MUL && count_q != '0) begin
            if ((WIDE'(acc_q) + WIDE'(aux_q)) > MAXVAL) begin
              state_d = ERRO;
            end else begin
              acc_d   = acc_q + {1'b0, aux_q};
              count_d = count_q - WIDTH'(1);
            end
          end else if (op_q == CMD_DIV && rem_q >= regb_q) begin
            rem_d = rem_q - regb_q;
            acc_d = acc_q + ACCW'(1);
          end else if (WIDE'(acc_q) > MAXVAL) begin
            state_d = ERRO;
          end else begin
            digits_d = acc_q[WIDTH-1:0];
            state_d  = RESULT;
          end
        end
        RESULT: begin
          if (accept && is_digit) begin
            digits_d = {{(WIDTH-4){1'b0}}, cmd};
            state_d  = ESPERA_A;
          end else if (accept && is_op) begin
            rega_d   = digits_q;
            op_d     = cmd;
            digits_d = '0;
            state_d  = ESPERA_B;
          end
        end
        ERRO:    state_d = ERRO;
        default: state_d = ESPERA_A;
      endcase
    end

    unique case (state_d)
      CALC:    status_d = ST_BUSY;
      RESULT:  status_d = ST_RESULT;
      ERRO:    status_d = ST_ERROR;
      default: status_d = ST_ENTER;
    endcase
    ready_d      = (state_d != CALC);
    conv_start_d = (digits_d != digits_q) || (state_q == ERRO && state_d != ERRO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ESPERA_A;
      digits_q     <= '0;
      rega_q       <= '0;
      regb_q       <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      aux_q        <= '0;
      rem_q        <= '0;
      op_q         <= CMD_ADD;
      setup_q      <= 1'b0;
      status_q     <= ST_ENTER;
      ready_q      <= 1'b1;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      rega_q       <= rega_d;
      regb_q       <= regb_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      aux_q        <= aux_d;
      rem_q        <= rem_d;
      op_q         <= op_d;
      setup_q      <= setup_d;
      status_q     <= status_d;
      ready_q      <= ready_d;
      conv_start_q <= conv_start_d;
    end
  end

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .NDIG  (NDIG)
  ) u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start_q),
    .bin   (digits_q),
    .busy  (conv_busy_unused),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Scanner: data is computed from pos_d so the registered digit lines up with pos.
  always_comb begin
    snap_d = conv_done ? conv_bcd : snap_q;
    if (div_q == DIVW'(SCAN_DIV - 1)) begin
      div_d = '0;
      pos_d = (pos_q == POSW'(NDIG - 1)) ? '0 : pos_q + POSW'(1);
    end else begin
      div_d = div_q + DIVW'(1);
      pos_d = pos_q;
    end
    msd = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (snap_q[4*i +: 4] != 4'd0) msd = POSW'(i);
    end
    if (state_d == ERRO)  data_d = ERR_GLYPH;
    else if (pos_d > msd) data_d = BLANK;
    else                  data_d = snap_q[4*int'(pos_d) +: 4];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_q <= '0;
      div_q  <= '0;
      pos_q  <= '0;
      data_q <= 4'd0;
    end else begin
      snap_q <= snap_d;
      div_q  <= div_d;
      pos_q  <= pos_d;
      data_q <= data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign status    = status_q;
  assign data      = data_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_calc_multi.sv
// Scoreboard bench for calc_multi: stimulus pushes expected results, a monitor
// pops them when the DUT leaves the busy state and checks latency and display.
module tb_calc_multi;
  import calc_pkg::*;

  localparam int NDIG     = 8;
  localparam int SCAN_DIV = 4;

  typedef struct {
    int         value;
    logic [1:0] st;
    int         lat;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] status;
  logic [3:0] data;
  logic [2:0] pos;

  exp_t       sb_q[$];
  int         errors;
  int         checks;
  bit         mon_active;
  logic [1:0] mon_prev;
  int         mon_busy_cnt;
  exp_t       mon_item;

  calc_multi #(
    .NDIG     (NDIG),
    .WIDTH    (27),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .status    (status),
    .data      (data),
    .pos       (pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] c);
    int n;
    n = 0;
    @(posedge clock);
    #1;
    while (!cmd_ready && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 500) check_output("ready_timeout", int'(cmd_ready), 1);
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_result(input int value, input logic [1:0] st, input int lat);
    exp_t e;
    e.value = value;
    e.st    = st;
    e.lat   = lat;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || mon_active) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    if (n >= 3000) begin
      check_output("idle_timeout_pending", sb_q.size(), 0);
      sb_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_display(input int value, input bit err);
    logic [3:0] seen [NDIG];
    bit         got  [NDIG];
    int         p10;
    logic [3:0] exp_g;
    for (int k = 0; k < NDIG; k++) begin
      got[k]  = 1'b0;
      seen[k] = 4'd0;
    end
    repeat (40) @(posedge clock);
    repeat (2 * NDIG * SCAN_DIV) begin
      @(negedge clock);
      seen[pos] = data;
      got[pos]  = 1'b1;
    end
    p10 = 1;
    for (int k = 0; k < NDIG; k++) begin
      if (err)                    exp_g = ERR_GLYPH;
      else if (k > 0 && value < p10) exp_g = BLANK;
      else                        exp_g = 4'((value / p10) % 10);
      check_output($sformatf("display_pos%0d", k), got[k] ? int'(seen[k]) : -1, int'(exp_g));
      p10 = p10 * 10;
    end
  endtask

  task automatic check_reset_values();
    check_output("reset_status", int'(status), int'(ST_ENTER));
    check_output("reset_ready", int'(cmd_ready), 1);
    check_output("reset_data", int'(data), 0);
    check_output("reset_pos", int'(pos), 0);
  endtask

  // Monitor: a result is presented when status leaves busy for result/error.
  initial begin
    mon_prev     = ST_ENTER;
    mon_busy_cnt = 0;
    mon_active   = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mon_busy_cnt = 0;
      end else if (status == ST_BUSY) begin
        mon_busy_cnt++;
      end else if (mon_prev == ST_BUSY) begin
        mon_active = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: status %0d with empty scoreboard", status);
        end else begin
          mon_item = sb_q.pop_front();
          check_output("result_status", int'(status), int'(mon_item.st));
          check_output("busy_clocks", mon_busy_cnt, mon_item.lat);
          check_display(mon_item.value, mon_item.st == ST_ERROR);
        end
        mon_busy_cnt = 0;
        mon_active   = 1'b0;
      end else begin
        mon_busy_cnt = 0;
      end
      mon_prev = status;
    end
  end

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    cmd       = 4'd0;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values();

    @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 72; i++) begin
      @(negedge clock);
      check_output($sformatf("scan_pos_%0d", i), int'(pos), (i / 4) % 8);
    end

    $display("[TB] 12 + 34");
    apply_stimulus(4'd1);
    apply_stimulus(4'd2);
    apply_stimulus(CMD_ADD);
    apply_stimulus(4'd3);
    apply_stimulus(4'd4);
    expect_result(46, ST_RESULT, 2);
    apply_stimulus(CMD_EQ);
    wait_idle();

    $display("[TB] 7 * 6 with cmd_valid held during CALC, then chained - 2");
    apply_stimulus(CMD_CLR);
    apply_stimulus(4'd7);
    apply_stimulus(CMD_MUL);
    apply_stimulus(4'd6);
    expect_result(42, ST_RESULT, 8);
    apply_stimulus(CMD_EQ);
    cmd       = 4'd9;
    cmd_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock);
      #1;
      if (cmd_ready) break;
    end
    cmd_valid = 1'b0;
    wait_idle();
    check_output("status_after_held_valid", int'(status), int'(ST_RESULT));
    apply_stimulus(CMD_SUB);
    apply_stimulus(4'd2);
    expect_result(40, ST_RESULT, 2);
    apply_stimulus(CMD_EQ);
    wait_idle();

    $display("[TB] 100 / 7");
    apply_stimulus(CMD_CLR);
    apply_stimulus(4'd1);
    apply_stimulus(4'd0);
    apply_stimulus(4'd0);
    apply_stimulus(CMD_DIV);
    apply_stimulus(4'd7);
    expect_result(14, ST_RESULT, 16);
    apply_stimulus(CMD_EQ);
    wait_idle();

    $display("[TB] 5 / 0 then clear");
    apply_stimulus(CMD_CLR);
    apply_stimulus(4'd5);
    apply_stimulus(CMD_DIV);
    apply_stimulus(4'd0);
    expect_result(0, ST_ERROR, 1);
    apply_stimulus(CMD_EQ);
    wait_idle();
    apply_stimulus(CMD_CLR);
    @(negedge clock);
    check_output("status_after_clear", int'(status), int'(ST_ENTER));
    check_display(0, 1'b0);

    $display("[TB] 5 - 9, commands ignored in error");
    apply_stimulus(4'd5);
    apply_stimulus(CMD_SUB);
    apply_stimulus(4'd9);
    expect_result(0, ST_ERROR, 1);
    apply_stimulus(CMD_EQ);
    wait_idle();
    apply_stimulus(4'd3);
    apply_stimulus(CMD_EQ);
    @(negedge clock);
    check_output("error_sticky", int'(status), int'(ST_ERROR));
    apply_stimulus(CMD_CLR);

    $display("[TB] nine 9s, then * 2 overflow");
    repeat (9) apply_stimulus(4'd9);
    check_display(99999999, 1'b0);
    apply_stimulus(CMD_MUL);
    apply_stimulus(4'd2);
    expect_result(0, ST_ERROR, 3);
    apply_stimulus(CMD_EQ);
    wait_idle();
    apply_stimulus(CMD_CLR);

    $display("[TB] reset during multiply");
    apply_stimulus(4'd9);
    apply_stimulus(CMD_MUL);
    apply_stimulus(4'd5);
    apply_stimulus(CMD_EQ);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_values();
    @(posedge clock);
    #1 reset = 1'b1;

    $display("[TB] 2 + 3 after reset");
    apply_stimulus(4'd2);
    apply_stimulus(CMD_ADD);
    apply_stimulus(4'd3);
    expect_result(5, ST_RESULT, 2);
    apply_stimulus(CMD_EQ);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_multi.md
Name: calc_multi

Overview:
- Parametrised successor to the single-digit-output calculator: decimal operand entry, operator, equals, and iterative ALU.
- Covers add, sub, multiply by successive addition, and divide by successive subtraction.
- Adds a cmd_valid/cmd_ready handshake, overflow and error detection, and result chaining.
- Drives a time-multiplexed NDIG-digit display with leading-zero blanking, from a BCD snapshot produced by a sequential binary-to-BCD converter.

Parameters:
- NDIG, 8: number of display digits; MAXVAL = 10^NDIG - 1.
- WIDTH, 27: operand/result register width; must satisfy 2^WIDTH > MAXVAL.
- SCAN_DIV, 4: clocks per display position (>= 1).
- POSW, $clog2(NDIG): derived width of pos.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd  in  4  command: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear.
- cmd_valid  in  1  cmd is accepted on a clock edge where cmd_valid && cmd_ready.
- cmd_ready  out  1  high when a command can be accepted.
- status  out  2  00 entering, 01 busy, 10 result valid, 11 error.
- data  out  4  BCD digit at pos; 4'hF = blank; 4'hE = error glyph.
- pos  out  POSW  display position being driven; 0 = least significant digit.

Behaviour:
- Reset (reset low, asynchronous):
  - State ESPERA_A; digits/regA/regB/acc/count = 0; op = add.
  - status = 00, cmd_ready = 1, data = 0, pos = 0, BCD snapshot = 0.
- Digit accept: if digits*10 + cmd <= MAXVAL, then digits <= digits*10 + cmd; otherwise the digit is dropped silently. Compute with WIDTH+4 bits.
- Clear (15): accepted in every state except CALC. Zeros all registers and goes to ESPERA_A.
- ESPERA_A:
  - Digit: accept as above.
  - Operator 10-13: regA <= digits, op <= cmd, digits <= 0, go to ESPERA_B.
  - 14: ignored.
- ESPERA_B:
  - Digit: accept as above.
  - Operator 10-13: replaces op only.
  - 14: regB <= digits, go to CALC.
- CALC: cmd_ready = 0, status = 01.
  - First CALC cycle (setup):
    - add: acc <= regA + regB (WIDTH+1 bits).
    - sub: regA < regB -> ERRO; else acc <= regA - regB.
    - mul: acc <= 0, count <= min(regA, regB), aux <= max(regA, regB).
    - div: regB == 0 -> ERRO; else acc (quotient) <= 0, rem <= regA.
  - Iteration, one step per clock:
    - mul: while count > 0, acc += aux and count -= 1; if acc + aux > MAXVAL -> ERRO immediately.
    - div: while rem >= regB, rem -= regB and acc += 1.
  - Completion: add/sub/mul/div result > MAXVAL -> ERRO; else digits <= acc, go to RESULT.
  - Latencies, accept to RESULT:
    - add/sub: 2 clocks.
    - mul: min(A,B) + 2 clocks.
    - div: floor(A/B) + 2 clocks.
- RESULT: status = 10.
  - Digit: digits <= cmd, go to ESPERA_A (starts a new entry).
  - Operator: regA <= digits, op <= cmd, digits <= 0, go to ESPERA_B (chaining).
  - 14: ignored.
- ERRO: status = 11; all positions show 4'hE. Only clear (15) exits; all other commands are accepted and ignored.
- BCD conversion:
  - Whenever digits changes, or ERRO is exited, the converter restarts on the new value.
  - Double-dabble takes WIDTH+1 clocks.
  - The display snapshot updates atomically at completion and is never partially updated.
  - A restart while busy aborts the old conversion.
- Display scanning:
  - pos advances every SCAN_DIV clocks, 0 to NDIG-1, then wraps to 0.
  - data = snapshot digit[pos].
  - Positions above the most significant nonzero digit show 4'hF; pos 0 always shows its digit, so a value of 0 displays "0".
  - Scanning never stops, including in CALC and ERRO.
- Simultaneous events: only one command per clock; cmd_valid with cmd_ready low is ignored (not queued).
- A reset assertion mid-CALC or mid-conversion aborts immediately to reset values.

Decomposition:
- Package calc_pkg:
  - estados_calc enum {ESPERA_A, ESPERA_B, CALC, RESULT, ERRO}.
  - cmd constants CMD_ADD=10, CMD_SUB=11, CMD_MUL=12, CMD_DIV=13, CMD_EQ=14, CMD_CLR=15.
  - status constants; BLANK=4'hF, ERR_GLYPH=4'hE.
- Sub-module bin2bcd_seq (parameters WIDTH, NDIG; ports start/busy/done/bin/bcd): sequential double-dabble.
- Display scanner: inline in calc_multi.

Test Plan:
- Enter 1,2, add, 3,4, equals -> status 10 two clocks after equals; after conversion, pos0=6, pos1=4, pos2..7=F.
- 7 mul 6 equals -> status 01 for exactly 8 clocks, then 10; display 42. Then sub, 2, equals -> chained result 40.
- 100 div 7 -> display 14 after 16 clocks. 5 div 0 -> status 11, all positions E; clear -> status 00, display "0".
- 5 sub 9 -> ERRO. 99999999 mul 2 -> ERRO; the overflow is flagged during iteration.
- Enter nine 9s -> digits stays 99999999 (ninth digit dropped). cmd_valid held high across CALC -> no extra commands accepted.
- Drop reset low mid-mul (count=3) -> next edge shows status 00, pos 0, data 0, cmd_ready 1. Scan check with SCAN_DIV=4 -> pos sequence 0..7, each held 4 clocks, wraps to 0.
